// File: rtl/sha_pkg.sv
// Shared SHA-256 constants, schedule state encoding and the small sigma functions
// used by both the message schedule and the compression datapath.
package sha_pkg;

   localparam int SHA_WORDS  = 16;
   localparam int SHA_ROUNDS = 64;

   typedef enum logic [2:0] {
      ST_LOAD = 3'b001,
      ST_FULL = 3'b010,
      ST_RUN  = 3'b100
   } sched_state_t;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/w_expand.sv
// Next schedule word from the sliding window: sigma1(w14) + w9 + sigma0(w1) + w0 mod 2^32.
// Purely combinational, no handshake.
module w_expand
   import sha_pkg::*;
(
   input  logic [31:0] w0,
   input  logic [31:0] w1,
   input  logic [31:0] w9,
   input  logic [31:0] w14,
   output logic [31:0] nw
);

   assign nw = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule: loads 16 words over valid/ready, then presents W_t on each
// enable with zero latency from a 16-word window; in_ready is low outside LOAD.
module sha_msg_sched
   import sha_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              block_full,
   input  logic              init,
   input  logic              enable,
   input  logic              done,
   output logic [WORD_W-1:0] w_t,
   output logic [5:0]        w_round,
   output logic              protocol_err
);

   localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

   sched_state_t      state;
   logic [3:0]        cnt;
   logic [5:0]        rnd;
   logic              exhausted;
   logic              err;
   logic [WORD_W-1:0] win [SHA_WORDS];
   logic [WORD_W-1:0] nw;

   w_expand u_w_expand (
      .w0  (win[0]),
      .w1  (win[1]),
      .w9  (win[9]),
      .w14 (win[14]),
      .nw  (nw)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_LOAD;
         cnt       <= 4'd0;
         rnd       <= 6'd0;
         exhausted <= 1'b0;
         err       <= 1'b0;
         for (int i = 0; i < SHA_WORDS; i++) begin
            win[i] <= '0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid) begin
                  win[cnt] <= in_data;
                  cnt      <= cnt + 4'd1;
                  if (cnt == 4'd15) begin
                     state <= ST_FULL;
                     cnt   <= 4'd0;
                  end
               end
            end
            ST_FULL: begin
               if (init) begin
                  state     <= ST_RUN;
                  rnd       <= 6'd0;
                  exhausted <= 1'b0;
               end
            end
            ST_RUN: begin
               // Last round's word stays on w_t; a further enable is a protocol error.
               if (enable) begin
                  if (rnd != LAST_RND) begin
                     for (int i = 0; i < SHA_WORDS - 1; i++) begin
                        win[i] <= win[i+1];
                     end
                     win[SHA_WORDS-1] <= nw;
                     rnd <= rnd + 6'd1;
                  end else begin
                     exhausted <= 1'b1;
                  end
               end
               if (done) begin
                  state <= ST_LOAD;
                  cnt   <= 4'd0;
               end
            end
            default: state <= ST_LOAD;
         endcase

         if ((init && state != ST_FULL) ||
             (enable && (state != ST_RUN || exhausted))) begin
            err <= 1'b1;
         end
      end
   end

   assign in_ready     = (state == ST_LOAD);
   assign block_full   = (state == ST_FULL);
   assign w_t          = win[0];
   assign w_round      = rnd;
   assign protocol_err = err;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: abc block, gapped loads/enables, protocol errors,
// reset mid-run, done+enable overlap and back-to-back reload against a reference schedule.
module tb_sha_msg_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        block_full;
   logic        init;
   logic        enable;
   logic        done;
   logic [31:0] w_t;
   logic [5:0]  w_round;
   logic        protocol_err;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] msg   [16];
   logic [31:0] exp_w [64];

   always #5 clk = ~clk;

   sha_msg_sched dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .block_full   (block_full),
      .init         (init),
      .enable       (enable),
      .done         (done),
      .w_t          (w_t),
      .w_round      (w_round),
      .protocol_err (protocol_err)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Textbook recurrence over the full W array.
   task automatic build_schedule();
      for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
      for (int t = 16; t < 64; t++)
         exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_msg(input bit gappy);
      for (int i = 0; i < 16; i++) begin
         if (gappy) begin
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
            init     = (i == 5);
            tick();
            init = 1'b0;
            if (i == 5) begin
               check("init_in_load_err", {31'b0, protocol_err}, 32'd1);
               check("init_in_load_ready", {31'b0, in_ready}, 32'd1);
            end
         end
         in_valid = 1'b1;
         in_data  = msg[i];
         tick();
         if (gappy && i == 14) check("full_before_16th", {31'b0, block_full}, 32'd0);
      end
      in_valid = 1'b0;
      check("block_full_after_16th", {31'b0, block_full}, 32'd1);
      check("in_ready_when_full", {31'b0, in_ready}, 32'd0);
   endtask

   task automatic run_block(input bit gaps, input bit abc);
      init = 1'b1;
      tick();
      init = 1'b0;
      check("run_start_round", {26'b0, w_round}, 32'd0);
      for (int t = 0; t < 64; t++) begin
         check($sformatf("w_t[%0d]", t), w_t, exp_w[t]);
         check($sformatf("w_round[%0d]", t), {26'b0, w_round}, 32'(t));
         if (abc && t == 16) check("abc_w16", w_t, 32'h61626380);
         if (abc && t == 17) check("abc_w17", w_t, 32'h000F0000);
         if (abc && t == 0)  check("abc_w0", w_t, 32'h61626380);
         if (gaps && (t % 16) == 7) begin
            enable = 1'b0;
            tick();
            check($sformatf("gap_hold_w_t[%0d]", t), w_t, exp_w[t]);
            check($sformatf("gap_hold_round[%0d]", t), {26'b0, w_round}, 32'(t));
         end
         enable = 1'b1;
         tick();
      end
      enable = 1'b0;
      check("end_round", {26'b0, w_round}, 32'd63);
      check("end_w_t", w_t, exp_w[63]);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 32'h0;
      init     = 1'b0;
      enable   = 1'b0;
      done     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_block_full", {31'b0, block_full}, 32'd0);
      check("rst_w_t", w_t, 32'd0);
      check("rst_w_round", {26'b0, w_round}, 32'd0);
      check("rst_err", {31'b0, protocol_err}, 32'd0);

      // abc block back-to-back, then back-pressure while full
      set_abc();
      build_schedule();
      load_msg(1'b0);
      in_valid = 1'b1;
      in_data  = 32'hFFFFFFFF;
      tick();
      in_valid = 1'b0;
      check("backpressure_full", {31'b0, block_full}, 32'd1);
      check("backpressure_no_err", {31'b0, protocol_err}, 32'd0);
      run_block(1'b1, 1'b1);
      check("abc_no_err", {31'b0, protocol_err}, 32'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("done_to_load", {31'b0, in_ready}, 32'd1);
      check("done_not_full", {31'b0, block_full}, 32'd0);

      // Second block, gapped load with init in LOAD; then a 65th enable
      for (int i = 0; i < 16; i++) msg[i] = 32'h9E3779B9 * (i + 1);
      build_schedule();
      load_msg(1'b1);
      run_block(1'b0, 1'b0);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      check("extra_enable_w_t", w_t, exp_w[63]);
      check("extra_enable_round", {26'b0, w_round}, 32'd63);
      check("err_sticky", {31'b0, protocol_err}, 32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;

      // Reset at round 30
      set_abc();
      build_schedule();
      load_msg(1'b0);
      init = 1'b1;
      tick();
      init = 1'b0;
      enable = 1'b1;
      for (int t = 0; t < 30; t++) tick();
      enable = 1'b0;
      check("round30_w_t", w_t, exp_w[30]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_w_round", {26'b0, w_round}, 32'd0);
      check("midrst_w_t", w_t, 32'd0);
      check("midrst_block_full", {31'b0, block_full}, 32'd0);
      check("midrst_err", {31'b0, protocol_err}, 32'd0);

      // enable outside RUN
      enable = 1'b1;
      tick();
      enable = 1'b0;
      check("enable_in_load_err", {31'b0, protocol_err}, 32'd1);
      check("enable_in_load_round", {26'b0, w_round}, 32'd0);
      check("enable_in_load_w_t", w_t, 32'd0);

      // done together with enable: shift lands, then back to LOAD
      load_msg(1'b0);
      init = 1'b1;
      tick();
      init = 1'b0;
      enable = 1'b1;
      for (int t = 0; t < 3; t++) tick();
      done = 1'b1;
      tick();
      done   = 1'b0;
      enable = 1'b0;
      check("done_enable_load", {31'b0, in_ready}, 32'd1);
      check("done_enable_w_t", w_t, exp_w[4]);
      check("done_enable_round", {26'b0, w_round}, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
